// File: rtl/attn_softmax_pkg.sv
// Shared constants and FSM encoding for the attention softmax row stages.
package attn_softmax_pkg;

  localparam int DATAWIDTH = 16;
  localparam int NUM       = 4;
  localparam int BEATS     = 8;

  // Most negative two's-complement word; the neutral start value for a max.
  localparam logic [DATAWIDTH-1:0] MIN_VAL = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } m1_state_e;

endpackage

// File: rtl/mode1_max_stream_if.sv
// Beat input, row-maximum output and status signals of the mode-1 max stage.
interface mode1_max_stream_if #(
  parameter int DATAWIDTH = 16
);

  logic                 start;
  logic                 inp_valid;
  logic [DATAWIDTH-1:0] inp0;
  logic [DATAWIDTH-1:0] inp1;
  logic [DATAWIDTH-1:0] inp2;
  logic [DATAWIDTH-1:0] inp3;
  logic                 inp_ready;
  logic [DATAWIDTH-1:0] max_out;
  logic                 max_valid;
  logic                 max_ready;
  logic                 busy;

  // Upstream/downstream side that feeds beats and consumes the maximum.
  modport master (
    output start, inp_valid, inp0, inp1, inp2, inp3, max_ready,
    input  inp_ready, max_out, max_valid, busy
  );

  // The max stage itself.
  modport slave (
    input  start, inp_valid, inp0, inp1, inp2, inp3, max_ready,
    output inp_ready, max_out, max_valid, busy
  );

endinterface

// File: rtl/mode1_max_stream_max4_signed.sv
// Purely combinational signed maximum of four words, two compare levels deep.
module max4_signed #(
  parameter int DATAWIDTH = 16
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] y
);

  logic [DATAWIDTH-1:0] max_ab;
  logic [DATAWIDTH-1:0] max_cd;

  // Pairwise compare, then final compare; a strict '>' keeps the earlier lane on ties.
  always_comb begin
    max_ab = ($signed(b) > $signed(a)) ? b : a;
    max_cd = ($signed(d) > $signed(c)) ? d : c;
    y      = ($signed(max_cd) > $signed(max_ab)) ? max_cd : max_ab;
  end

endmodule

// File: rtl/mode1_max_stream.sv
// Mode-1 softmax stage: streams one row of beats and reports its signed maximum.
module mode1_max_stream #(
  parameter int DATAWIDTH = attn_softmax_pkg::DATAWIDTH,
  parameter int BEATS     = attn_softmax_pkg::BEATS
) (
  input logic              clk,
  input logic              rst,
  mode1_max_stream_if.slave bus
);

  import attn_softmax_pkg::*;

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]        LAST_BEAT = CW'(BEATS - 1);
  localparam logic [DATAWIDTH-1:0] MIN_WORD  = MIN_VAL;

  m1_state_e            state_q, state_d;
  logic [DATAWIDTH-1:0] run_max_q, run_max_d;
  logic [DATAWIDTH-1:0] max_out_q, max_out_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] beat_max;
  logic [DATAWIDTH-1:0] merged_max;
  logic                 accept;

  max4_signed #(.DATAWIDTH(DATAWIDTH)) u_max4 (
    .a (bus.inp0),
    .b (bus.inp1),
    .c (bus.inp2),
    .d (bus.inp3),
    .y (beat_max)
  );

  // Fold the beat maximum into the running maximum; the running value wins ties.
  always_comb begin
    merged_max = ($signed(beat_max) > $signed(run_max_q)) ? beat_max : run_max_q;
    accept     = (state_q == ACCUM) && bus.inp_valid;
  end

  // Next-state logic: start loads the row, accepted beats fold in, last beat publishes.
  always_comb begin
    state_d   = state_q;
    run_max_d = run_max_q;
    max_out_d = max_out_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = ACCUM;
          run_max_d = MIN_WORD;
          cnt_d     = '0;
        end
      end
      ACCUM: begin
        if (accept) begin
          run_max_d = merged_max;
          if (cnt_q == LAST_BEAT) begin
            state_d   = DONE;
            cnt_d     = '0;
            max_out_d = merged_max;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.max_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any partial row and clears the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      run_max_q <= '0;
      max_out_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_max_q <= run_max_d;
      max_out_q <= max_out_d;
      cnt_q     <= cnt_d;
    end
  end

  // Handshake and status outputs decode directly from the registered state.
  always_comb begin
    bus.inp_ready = (state_q == ACCUM);
    bus.max_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.max_out   = max_out_q;
  end

endmodule

// File: tb/tb_mode1_max_stream.sv
// Self-checking bench for mode1_max_stream with a queue of expected row maxima.
module tb_mode1_max_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mode1_max_stream_if #(.DATAWIDTH(16)) bus ();

  mode1_max_stream #(.DATAWIDTH(16), .BEATS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] row_words [32];
  logic [15:0] exp_q [$];
  logic [15:0] exp_val;

  // Reference maximum of the current row as a linear signed scan.
  function automatic logic [15:0] model_max();
    logic signed [15:0] m;
    m = 16'sh8000;
    for (int k = 0; k < 32; k++) begin
      if ($signed(row_words[k]) > m) m = $signed(row_words[k]);
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Drive beats first..last, inserting 'gap' idle cycles before every beat after the first.
  task automatic drive_beats(input int first, input int last, input int gap);
    for (int b = first; b <= last; b++) begin
      if (b != first) begin
        for (int g = 0; g < gap; g++) begin
          bus.inp_valid = 1'b0;
          bus.inp0 = 16'($urandom);
          bus.inp1 = 16'h7FFF;
          bus.inp2 = 16'($urandom);
          bus.inp3 = 16'h7FFF;
          tick();
        end
      end
      bus.inp0 = row_words[4*b];
      bus.inp1 = row_words[4*b+1];
      bus.inp2 = row_words[4*b+2];
      bus.inp3 = row_words[4*b+3];
      bus.inp_valid = 1'b1;
      tick();
    end
    bus.inp_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks += 4;
    if (bus.inp_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_inp_ready got %b want 0", bus.inp_ready); end
    if (bus.max_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_max_valid got %b want 0", bus.max_valid); end
    if (bus.busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.max_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_max_out got %h want 0000", bus.max_out); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ascending();
    for (int k = 0; k < 32; k++) row_words[k] = 16'(k + 1);
    exp_q.push_back(model_max());
    start_row();
    drive_beats(0, 6, 0);
    @(negedge clk);
    checks += 2;
    if (bus.max_valid !== 1'b0) begin errors++; $display("[TB] FAIL asc_valid_early got %b want 0", bus.max_valid); end
    if (bus.inp_ready !== 1'b1) begin errors++; $display("[TB] FAIL asc_inp_ready got %b want 1", bus.inp_ready); end
    drive_beats(7, 7, 0);
    @(negedge clk);
    exp_val = exp_q.pop_front();
    checks += 4;
    if (bus.max_valid !== 1'b1) begin errors++; $display("[TB] FAIL asc_valid_latency got %b want 1", bus.max_valid); end
    if (bus.inp_ready !== 1'b0) begin errors++; $display("[TB] FAIL asc_ready_done got %b want 0", bus.inp_ready); end
    if (bus.max_out !== exp_val) begin errors++; $display("[TB] FAIL asc_max got %h want %h", bus.max_out, exp_val); end
    if (bus.max_out !== 16'h0020) begin errors++; $display("[TB] FAIL asc_max_const got %h want 0020", bus.max_out); end
    bus.max_ready = 1'b1;
    tick();
    bus.max_ready = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.max_valid !== 1'b0) begin errors++; $display("[TB] FAIL asc_idle_valid got %b want 0", bus.max_valid); end
    if (bus.busy !== 1'b0)      begin errors++; $display("[TB] FAIL asc_idle_busy got %b want 0", bus.busy); end
    if (bus.max_out !== exp_val) begin errors++; $display("[TB] FAIL asc_retain got %h want %h", bus.max_out, exp_val); end
  endtask

  task automatic test_negative();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 32; k++) row_words[k] = 16'h8001 + 16'($urandom_range(0, 16'h7FEE));
      if (r == 0) begin
        row_words[5]  = 16'h8000;
        row_words[14] = 16'hFFF0;
      end else if (r == 1) begin
        for (int k = 0; k < 32; k++) row_words[k] = 16'h8000;
      end else begin
        row_words[9]  = 16'h8000;
        row_words[27] = 16'hFFFF;
      end
      exp_q.push_back(model_max());
      start_row();
      drive_beats(0, 7, 0);
      @(negedge clk);
      exp_val = exp_q.pop_front();
      checks += 2;
      if (bus.max_valid !== 1'b1) begin errors++; $display("[TB] FAIL neg%0d_valid got %b want 1", r, bus.max_valid); end
      if (bus.max_out !== exp_val) begin errors++; $display("[TB] FAIL neg%0d_max got %h want %h", r, bus.max_out, exp_val); end
      if (r == 0) begin
        checks++;
        if (bus.max_out !== 16'hFFF0) begin errors++; $display("[TB] FAIL neg0_max_const got %h want fff0", bus.max_out); end
      end
      bus.max_ready = 1'b1;
      tick();
      bus.max_ready = 1'b0;
    end
  endtask

  task automatic test_bubbles();
    for (int k = 0; k < 32; k++) row_words[k] = 16'($urandom);
    exp_q.push_back(model_max());
    start_row();
    drive_beats(0, 6, 2);
    @(negedge clk);
    checks += 2;
    if (bus.max_valid !== 1'b0) begin errors++; $display("[TB] FAIL bub_valid_early got %b want 0", bus.max_valid); end
    if (bus.busy !== 1'b1)      begin errors++; $display("[TB] FAIL bub_busy got %b want 1", bus.busy); end
    drive_beats(7, 7, 2);
    exp_val = exp_q.pop_front();
    bus.max_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks += 2;
      if (bus.max_valid !== 1'b1) begin errors++; $display("[TB] FAIL bub_hold%0d_valid got %b want 1", c, bus.max_valid); end
      if (bus.max_out !== exp_val) begin errors++; $display("[TB] FAIL bub_hold%0d_max got %h want %h", c, bus.max_out, exp_val); end
    end
    bus.max_ready = 1'b1;
    tick();
    bus.max_ready = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.busy !== 1'b0)      begin errors++; $display("[TB] FAIL bub_idle_busy got %b want 0", bus.busy); end
    if (bus.max_valid !== 1'b0) begin errors++; $display("[TB] FAIL bub_idle_valid got %b want 0", bus.max_valid); end
  endtask

  task automatic test_ignored();
    bus.inp0 = 16'h7FFF; bus.inp1 = 16'h7FFF; bus.inp2 = 16'h7FFF; bus.inp3 = 16'h7FFF;
    bus.inp_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks += 2;
      if (bus.inp_ready !== 1'b0) begin errors++; $display("[TB] FAIL ign_idle_ready got %b want 0", bus.inp_ready); end
      if (bus.busy !== 1'b0)      begin errors++; $display("[TB] FAIL ign_idle_busy got %b want 0", bus.busy); end
    end
    bus.inp_valid = 1'b0;
    for (int k = 0; k < 32; k++) row_words[k] = 16'h0010;
    exp_q.push_back(model_max());
    start_row();
    drive_beats(0, 2, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drive_beats(3, 7, 0);
    @(negedge clk);
    exp_val = exp_q.pop_front();
    checks += 2;
    if (bus.max_valid !== 1'b1) begin errors++; $display("[TB] FAIL ign_accum_start got %b want 1", bus.max_valid); end
    if (bus.max_out !== exp_val) begin errors++; $display("[TB] FAIL ign_max got %h want %h", bus.max_out, exp_val); end
    bus.start = 1'b1;
    bus.inp0 = 16'h7FFF; bus.inp1 = 16'h7FFF; bus.inp2 = 16'h7FFF; bus.inp3 = 16'h7FFF;
    bus.inp_valid = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    bus.inp_valid = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.max_valid !== 1'b1) begin errors++; $display("[TB] FAIL ign_done_valid got %b want 1", bus.max_valid); end
    if (bus.max_out !== exp_val) begin errors++; $display("[TB] FAIL ign_done_max got %h want %h", bus.max_out, exp_val); end
    if (bus.inp_ready !== 1'b0) begin errors++; $display("[TB] FAIL ign_done_ready got %b want 0", bus.inp_ready); end
    bus.max_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.max_ready = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_hs_start got %b want 0", bus.busy); end
    tick();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_hs_start_late got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_midrow();
    for (int k = 0; k < 32; k++) row_words[k] = 16'h0100 + 16'(k);
    start_row();
    drive_beats(0, 3, 0);
    #2;
    rst = 1'b0;
    #1;
    checks += 4;
    if (bus.busy !== 1'b0)        begin errors++; $display("[TB] FAIL mid_rst_busy got %b want 0", bus.busy); end
    if (bus.inp_ready !== 1'b0)   begin errors++; $display("[TB] FAIL mid_rst_ready got %b want 0", bus.inp_ready); end
    if (bus.max_valid !== 1'b0)   begin errors++; $display("[TB] FAIL mid_rst_valid got %b want 0", bus.max_valid); end
    if (bus.max_out !== 16'h0000) begin errors++; $display("[TB] FAIL mid_rst_max got %h want 0000", bus.max_out); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_wait_idle got %b want 0", bus.busy); end
    for (int k = 0; k < 32; k++) row_words[k] = 16'h0005;
    exp_q.push_back(model_max());
    start_row();
    drive_beats(0, 7, 0);
    @(negedge clk);
    exp_val = exp_q.pop_front();
    checks += 3;
    if (bus.max_valid !== 1'b1)   begin errors++; $display("[TB] FAIL mid_new_valid got %b want 1", bus.max_valid); end
    if (bus.max_out !== exp_val)  begin errors++; $display("[TB] FAIL mid_new_max got %h want %h", bus.max_out, exp_val); end
    if (bus.max_out !== 16'h0005) begin errors++; $display("[TB] FAIL mid_new_const got %h want 0005", bus.max_out); end
    bus.max_ready = 1'b1;
    tick();
    bus.max_ready = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.inp_valid = 1'b0;
    bus.inp0 = '0; bus.inp1 = '0; bus.inp2 = '0; bus.inp3 = '0;
    bus.max_ready = 1'b0;
    test_reset();
    test_ascending();
    test_negative();
    test_bubbles();
    test_ignored();
    test_reset_midrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
